apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin arbiter driving a single APB
// master port, with a per-transfer ACCESS-phase wait timeout.
//
// Ports
//   PCLK, PRESETn            clock, synchronous active-low reset
//   req[1:0]                 per-requester request, held until done
//   req_write[1:0]           per-requester direction (1 = write)
//   req_addr[2*ADDR_W-1:0]   requester n address at [n*ADDR_W +: ADDR_W]
//   req_wdata[2*DATA_W-1:0]  requester n write data at [n*DATA_W +: DATA_W]
//   gnt[1:0]                 one-hot owner of the transfer in flight
//   done[1:0]                one-cycle completion pulse to the owner
//   rsp_rdata/err/timeout    response, valid with done, held until next done
//   PSEL..PWDATA             APB master outputs
//   PREADY, PSLVERR, PRDATA  APB slave responses
module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [1:0]            req,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_W-1:0]     PRDATA
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              prio_q, prio_d;   // requester index holding priority

  logic              win_idx_c;

  // Round-robin pick: on contention the priority holder wins, else the lone requester.
  always_comb begin
    if (req == 2'b11) win_idx_c = prio_q;
    else              win_idx_c = req[1];
  end

  // Next-state and output computation.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    wait_d    = wait_q;
    prio_d    = prio_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          gnt_d     = win_idx_c ? 2'b10 : 2'b01;
          prio_d    = ~win_idx_c;
          wait_d    = '0;
          pwrite_d  = win_idx_c ? req_write[1] : req_write[0];
          paddr_d   = win_idx_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d  = win_idx_c ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PREADY wins over the timeout in the cycle the counter would expire.
        if (PREADY) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = 2'b00;
          done_d    = gnt_q;
          rdata_d   = pwrite_q ? '0 : PRDATA;
          err_d     = PSLVERR;
          tmo_d     = 1'b0;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = 2'b00;
          done_d    = gnt_q;
          rdata_d   = '0;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          wait_d    = wait_q + CNT_W'(1);
        end else begin
          wait_d    = wait_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        gnt_d     = 2'b00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      wait_q    <= '0;
      prio_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
      prio_q    <= prio_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench for apb_master_arbiter. Expected
// transfers are queued when requests are driven; the bench-side slave answers
// from the queue head and each done pulse pops and compares one entry.
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    logic [1:0]  owner;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    int          wt;      // ACCESS cycles the slave stalls before PREADY
    logic        perr;
    logic [31:0] prdata;
    logic [31:0] rdata;   // expected rsp_rdata
    logic        err;
    logic        tmo;
    int          acc;     // expected ACCESS-phase length
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   prev_setup = -1;
  int   ctn_left = 0;
  logic hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int n, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input int wt, input logic perr, input logic [31:0] prd, input logic tmo);
    exp_t e;
    e.owner  = (n == 1) ? 2'b10 : 2'b01;
    e.addr   = a;
    e.wr     = wr;
    e.wdata  = wd;
    e.wt     = wt;
    e.perr   = perr;
    e.prdata = prd;
    e.rdata  = (wr || tmo) ? 32'h0 : prd;
    e.err    = tmo | perr;
    e.tmo    = tmo;
    e.acc    = tmo ? 16 : wt + 1;
    exp_q.push_back(e);
    if (n == 1) begin
      req_write[1]       = wr;
      req_addr[15:8]     = a;
      req_wdata[63:32]   = wd;
    end else begin
      req_write[0]       = wr;
      req_addr[7:0]      = a;
      req_wdata[31:0]    = wd;
    end
  endtask

  // Per-cycle monitor, scoreboard and APB slave, run at each falling edge.
  task automatic mon();
    exp_t e;
    cyc++;
    if (PSEL && !PENABLE) begin
      if (exp_q.size() == 0) begin
        chk("setup_unexpected_gnt", 64'(gnt), 64'(0));
      end else begin
        chk("setup_gnt",    64'(gnt),    64'(exp_q[0].owner));
        chk("setup_paddr",  64'(PADDR),  64'(exp_q[0].addr));
        chk("setup_pwrite", 64'(PWRITE), 64'(exp_q[0].wr));
        chk("setup_pwdata", 64'(PWDATA), 64'(exp_q[0].wdata));
      end
      if (hold && prev_setup >= 0) chk("rr_period", 64'(cyc - prev_setup), 64'(3));
      prev_setup = cyc;
      acc_cnt = 0;
    end
    if (PSEL && PENABLE && exp_q.size() > 0) begin
      chk("access_paddr", 64'(PADDR),  64'(exp_q[0].addr));
      chk("access_gnt",   64'(gnt),    64'(exp_q[0].owner));
    end
    if (done != 2'b00) begin
      chk("done_onehot", 64'($countones(done) <= 1), 64'(1));
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 64'(done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("done_owner",   64'(done),        64'(e.owner));
        chk("rsp_rdata",    64'(rsp_rdata),   64'(e.rdata));
        chk("rsp_err",      64'(rsp_err),     64'(e.err));
        chk("rsp_timeout",  64'(rsp_timeout), 64'(e.tmo));
        chk("access_len",   64'(acc_cnt),     64'(e.acc));
      end
      if (hold) begin
        ctn_left--;
        if (ctn_left == 0) req = 2'b00;
      end else begin
        req = req & ~done;
      end
    end
    if (PSEL && PENABLE && exp_q.size() > 0) begin
      PREADY  = (acc_cnt == exp_q[0].wt);
      PSLVERR = exp_q[0].perr;
      PRDATA  = exp_q[0].prdata;
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 32'hDEADBEEF;
    end
  endtask

  task automatic step();
    @(negedge PCLK);
    mon();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_psel"},    64'(PSEL),        64'(0));
    chk({pfx, "_penable"}, 64'(PENABLE),     64'(0));
    chk({pfx, "_gnt"},     64'(gnt),         64'(0));
    chk({pfx, "_done"},    64'(done),        64'(0));
    chk({pfx, "_paddr"},   64'(PADDR),       64'(0));
    chk({pfx, "_pwdata"},  64'(PWDATA),      64'(0));
    chk({pfx, "_pwrite"},  64'(PWRITE),      64'(0));
    chk({pfx, "_rdata"},   64'(rsp_rdata),   64'(0));
    chk({pfx, "_err"},     64'(rsp_err),     64'(0));
    chk({pfx, "_tmo"},     64'(rsp_timeout), 64'(0));
  endtask

  initial begin
    int n;
    PRESETn   = 1'b0;
    req       = 2'b00;
    req_write = 2'b00;
    req_addr  = 16'h0;
    req_wdata = 64'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = 32'h0;
    repeat (3) step();
    chk_zero_outputs("reset");
    PRESETn = 1'b1;
    step();

    // Single write, zero wait states.
    push(0, 1'b1, 8'h10, 32'hA5A5A5A5, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    req[0] = 1'b1;
    drain(50);
    step();

    // Read on requester 1 with three wait states.
    push(1, 1'b0, 8'h20, 32'h0, 3, 1'b0, 32'h12345678, 1'b0);
    req[1] = 1'b1;
    drain(50);
    step();

    // Slave error on a write.
    push(0, 1'b1, 8'h30, 32'hCAFEF00D, 0, 1'b1, 32'hDEADBEEF, 1'b0);
    req[0] = 1'b1;
    drain(50);
    step();

    // Slave never ready: timeout abort after 16 ACCESS cycles.
    push(1, 1'b0, 8'h44, 32'h0, 1000, 1'b0, 32'h55AA55AA, 1'b1);
    req[1] = 1'b1;
    drain(100);
    step();

    // Contention with both requests held: grants alternate 0,1,0,1.
    hold = 1'b1;
    ctn_left = 4;
    prev_setup = -1;
    push(0, 1'b1, 8'h11, 32'h11111111, 0, 1'b0, 32'h0, 1'b0);
    push(1, 1'b1, 8'h21, 32'h22222222, 0, 1'b0, 32'h0, 1'b0);
    push(0, 1'b1, 8'h11, 32'h11111111, 0, 1'b0, 32'h0, 1'b0);
    push(1, 1'b1, 8'h21, 32'h22222222, 0, 1'b0, 32'h0, 1'b0);
    req = 2'b11;
    drain(100);
    hold = 1'b0;
    step();
    step();
    chk("ctn_no_extra_psel", 64'(PSEL), 64'(0));

    // PREADY arrives in the cycle the timeout would fire: normal completion.
    push(0, 1'b0, 8'h50, 32'h0, 15, 1'b1, 32'h0BADF00D, 1'b0);
    req[0] = 1'b1;
    drain(100);
    step();

    // Reset mid-wait: no done, outputs cleared, priority back to requester 0.
    push(0, 1'b0, 8'h60, 32'h0, 1000, 1'b0, 32'h77777777, 1'b0);
    req[0] = 1'b1;
    n = 0;
    while (!(PSEL && PENABLE && acc_cnt >= 3) && n < 50) begin
      step();
      n++;
    end
    chk("reached_access", 64'(PENABLE), 64'(1));
    PRESETn = 1'b0;
    req = 2'b00;
    step();
    chk_zero_outputs("abort");
    exp_q.delete();
    PRESETn = 1'b1;
    step();
    step();
    chk("abort_no_done", 64'(done), 64'(0));

    push(0, 1'b1, 8'h70, 32'h70707070, 0, 1'b0, 32'h0, 1'b0);
    push(1, 1'b0, 8'h71, 32'h0, 2, 1'b0, 32'h71717171, 1'b0);
    req = 2'b11;
    drain(100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
